// File: rtl/bus_rr_if.sv
// bus_rr_if: signal bundle for the bus_rr shared-bus interconnect.
//
// Master side (one lane per master, packed):
//   m_req_, m_as_, m_rw       request / address strobe / read(1)-write(0)
//   m_addr, m_wr_data         packed address and write data, lane i at [i*W +: W]
//   m_grnt_                   one-hot-low grant
//   m_rd_data, m_rdy_, m_err  broadcast completion
// Slave side:
//   s_addr, s_as_, s_rw, s_wr_data, s_cs_   owner's access steered to the slaves
//   s_rd_data, s_rdy_                       packed slave responses
//
// Handshake: a master holds req_, as_, addr, rw and wr_data stable until it
// samples m_rdy_ = 0 on a rising clock edge; that edge ends the access.
// m_err is meaningful only while m_rdy_ = 0.
//
// Modports: fabric = the interconnect, master = the requesters,
// slave = the targets.
interface bus_rr_if #(
   parameter int NUM_M  = 4,
   parameter int NUM_S  = 8,
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic [NUM_M-1:0]        m_req_;
   logic [NUM_M-1:0]        m_grnt_;
   logic [NUM_M*ADDR_W-1:0] m_addr;
   logic [NUM_M-1:0]        m_as_;
   logic [NUM_M-1:0]        m_rw;
   logic [NUM_M*DATA_W-1:0] m_wr_data;
   logic [DATA_W-1:0]       m_rd_data;
   logic                    m_rdy_;
   logic                    m_err;

   logic [ADDR_W-1:0]       s_addr;
   logic                    s_as_;
   logic                    s_rw;
   logic [DATA_W-1:0]       s_wr_data;
   logic [NUM_S-1:0]        s_cs_;
   logic [NUM_S*DATA_W-1:0] s_rd_data;
   logic [NUM_S-1:0]        s_rdy_;

   modport fabric (
      input  m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
      output m_grnt_, m_rd_data, m_rdy_, m_err,
      output s_addr, s_as_, s_rw, s_wr_data, s_cs_
   );

   modport master (
      output m_req_, m_addr, m_as_, m_rw, m_wr_data,
      input  m_grnt_, m_rd_data, m_rdy_, m_err
   );

   modport slave (
      input  s_addr, s_as_, s_rw, s_wr_data, s_cs_,
      output s_rd_data, s_rdy_
   );
endinterface

// File: rtl/bus_rr.sv
// bus_rr: parametrised shared-bus interconnect with a registered
// round-robin arbiter, slave-population mask and per-access watchdog.
//
// Ports:
//   clk        bus clock
//   rst        synchronous active-low reset
//   bus        bus_rr_if.fabric bundle (master and slave sides)
//   dbg_owner  current bus owner (registered)
//   dbg_state  watchdog state: 1 = WAIT, 0 = IDLE (registered)
//   dbg_wcnt   watchdog wait counter (registered)
//
// Datapath is combinational from the registered owner: the owner's lane is
// muxed onto the slave side, the top address bits pick a slave window, and
// the selected slave's response is broadcast back. An access to an
// unpopulated window, or one that waits TIMEOUT cycles, is completed by the
// interconnect itself with m_err = 1.
module bus_rr #(
   parameter int              NUM_M   = 4,
   parameter int              NUM_S   = 8,
   parameter int              ADDR_W  = 30,
   parameter int              DATA_W  = 32,
   parameter logic [NUM_S-1:0] S_EN   = '1,
   parameter int              TIMEOUT = 255,
   localparam int             OW      = (NUM_M > 1) ? $clog2(NUM_M) : 1,
   localparam int             WW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic          clk,
   input  logic          rst,
   bus_rr_if.fabric      bus,
   output logic [OW-1:0] dbg_owner,
   output logic          dbg_state,
   output logic [WW-1:0] dbg_wcnt
);

   localparam int          SW     = $clog2(NUM_S);
   localparam logic [WW-1:0] TO_VAL = WW'(TIMEOUT);
   localparam bit          WD_ON  = (TIMEOUT != 0);

   typedef enum logic {
      WD_IDLE = 1'b0,
      WD_WAIT = 1'b1
   } wd_state_t;

   logic [OW-1:0]     owner;
   logic [OW-1:0]     owner_nxt;
   logic [OW-1:0]     arb_cand;
   logic              arb_found;
   wd_state_t         wd_state;
   logic [WW-1:0]     wcnt;

   logic [ADDR_W-1:0] own_addr;
   logic [SW-1:0]     sel;
   logic              populated;
   logic              strobe;
   logic              cs_act;
   logic              bad_sel;
   logic              sel_rdy_;
   logic [DATA_W-1:0] sel_data;
   logic              timeout_hit;

   // ------------------------------------------------------------------
   // Round-robin arbiter: the owner keeps the bus while it requests;
   // otherwise the first requester after it (cyclically) wins. With no
   // requester the owner is kept, so exactly one grant is always low.
   // ------------------------------------------------------------------
   always_comb begin
      owner_nxt = owner;
      arb_cand  = owner;
      arb_found = 1'b0;
      if (bus.m_req_[owner]) begin
         for (int k = 1; k < NUM_M; k++) begin
            arb_cand = OW'((int'(owner) + k) % NUM_M);
            if (!arb_found && !bus.m_req_[arb_cand]) begin
               owner_nxt = arb_cand;
               arb_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.m_grnt_ = ~({{(NUM_M-1){1'b0}}, 1'b1} << owner);
   end

   // ------------------------------------------------------------------
   // Master mux and address decode.
   // ------------------------------------------------------------------
   always_comb begin
      own_addr      = bus.m_addr[int'(owner) * ADDR_W +: ADDR_W];
      bus.s_addr    = own_addr;
      bus.s_rw      = bus.m_rw[owner];
      bus.s_wr_data = bus.m_wr_data[int'(owner) * DATA_W +: DATA_W];
      sel           = own_addr[ADDR_W-1 -: SW];
      populated     = S_EN[sel];
      // Reset masks the strobe, which in turn quiets every output path.
      strobe        = rst & ~bus.m_as_[owner];
      cs_act        = strobe & populated;
      bad_sel       = strobe & ~populated;
      sel_rdy_      = bus.s_rdy_[sel];
      sel_data      = bus.s_rd_data[int'(sel) * DATA_W +: DATA_W];
   end

   always_comb begin
      bus.s_as_ = ~cs_act;
      bus.s_cs_ = '1;
      if (cs_act) begin
         bus.s_cs_ = ~({{(NUM_S-1){1'b0}}, 1'b1} << sel);
      end
   end

   // The watchdog fires in the cycle its counter reaches TIMEOUT.
   always_comb begin
      timeout_hit = WD_ON && (wd_state == WD_WAIT) && (wcnt == TO_VAL);
   end

   // ------------------------------------------------------------------
   // Slave response mux. A slave that becomes ready in the timeout cycle
   // takes precedence over the watchdog error.
   // ------------------------------------------------------------------
   always_comb begin
      bus.m_rd_data = '0;
      bus.m_rdy_    = 1'b1;
      bus.m_err     = 1'b0;
      if (bad_sel) begin
         bus.m_rdy_ = 1'b0;
         bus.m_err  = 1'b1;
      end else if (cs_act) begin
         if (timeout_hit && sel_rdy_) begin
            bus.m_rdy_ = 1'b0;
            bus.m_err  = 1'b1;
         end else begin
            bus.m_rd_data = sel_data;
            bus.m_rdy_    = sel_rdy_;
         end
      end
   end

   // ------------------------------------------------------------------
   // Owner register and watchdog FSM.
   // IDLE -> WAIT when a populated access is strobed but the slave is not
   // ready; the counter then shows how many cycles the access has waited.
   // WAIT -> IDLE on slave ready, strobe release or timeout.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner    <= '0;
         wd_state <= WD_IDLE;
         wcnt     <= '0;
      end else begin
         owner <= owner_nxt;
         case (wd_state)
            WD_IDLE: begin
               if (WD_ON && cs_act && sel_rdy_) begin
                  wd_state <= WD_WAIT;
                  wcnt     <= WW'(1);
               end
            end
            WD_WAIT: begin
               if (!cs_act || !sel_rdy_ || (wcnt == TO_VAL)) begin
                  wd_state <= WD_IDLE;
                  wcnt     <= '0;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            default: begin
               wd_state <= WD_IDLE;
               wcnt     <= '0;
            end
         endcase
      end
   end

   always_comb begin
      dbg_owner = owner;
      dbg_state = (wd_state == WD_WAIT);
      dbg_wcnt  = wcnt;
   end

endmodule

// File: tb/tb_bus_rr.sv
module tb_bus_rr;
   localparam int         NM  = 4;
   localparam int         NS  = 8;
   localparam int         AW  = 30;
   localparam int         DW  = 32;
   localparam logic [7:0] SEN = 8'h7F;
   localparam int         TMO = 4;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_owner;
   logic       dbg_state;
   logic [2:0] dbg_wcnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] exp_q[$];

   bus_rr_if #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

   bus_rr #(
      .NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW),
      .S_EN(SEN), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .dbg_owner(dbg_owner), .dbg_state(dbg_state), .dbg_wcnt(dbg_wcnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
      $fatal(1, "global timeout");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_master(input int i, input logic req_n, input logic as_n,
                               input logic [AW-1:0] addr, input logic rw,
                               input logic [DW-1:0] wd);
      bus.m_req_[i]            = req_n;
      bus.m_as_[i]             = as_n;
      bus.m_addr[i*AW +: AW]   = addr;
      bus.m_rw[i]              = rw;
      bus.m_wr_data[i*DW +: DW] = wd;
   endtask

   task automatic drive_slave(input int j, input logic rdy_n, input logic [DW-1:0] d);
      bus.s_rdy_[j]              = rdy_n;
      bus.s_rd_data[j*DW +: DW]  = d;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NM; i++) drive_master(i, 1'b1, 1'b1, AW'($urandom), 1'b1, $urandom);
      for (int j = 0; j < NS; j++) drive_slave(j, 1'b1, $urandom);
   endtask

   function automatic logic [AW-1:0] mk_addr(input int sel, input int low);
      return {3'(sel), 27'(low)};
   endfunction

   // scenarios
   task automatic test_reset();
      rst = 1'b0;
      idle_all();
      // strobe an access to a populated, ready slave while reset is held
      drive_master(0, 1'b0, 1'b0, mk_addr(0, 5), 1'b1, 0);
      drive_slave(0, 1'b0, 32'hCAFE_0000);
      repeat (3) step();
      n_tests++; if (bus.s_as_ !== 1'b1) begin n_fail++; $display("FAIL rst_s_as: got %b expected 1", bus.s_as_); end
      n_tests++; if (bus.m_rdy_ !== 1'b1) begin n_fail++; $display("FAIL rst_m_rdy: got %b expected 1", bus.m_rdy_); end
      n_tests++; if (bus.s_cs_ !== 8'hFF) begin n_fail++; $display("FAIL rst_s_cs: got %h expected ff", bus.s_cs_); end
      idle_all();
      rst = 1'b1;
      #1;
      n_tests++; if (bus.m_grnt_ !== 4'b1110) begin n_fail++; $display("FAIL reset_grant: got %b expected 1110", bus.m_grnt_); end
      n_tests++; if (bus.s_as_ !== 1'b1) begin n_fail++; $display("FAIL reset_s_as: got %b expected 1", bus.s_as_); end
      n_tests++; if (bus.m_rdy_ !== 1'b1 || bus.m_err !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_err: got %b/%b expected 1/0", bus.m_rdy_, bus.m_err); end
      n_tests++; if (bus.m_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", bus.m_rd_data); end
      n_tests++; if (dbg_owner !== 2'd0 || dbg_wcnt !== 3'd0 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_regs: got owner %0d wcnt %0d state %b expected 0 0 0", dbg_owner, dbg_wcnt, dbg_state); end
   endtask

   task automatic test_round_robin();
      logic [1:0]    k;
      logic [AW-1:0] a;
      exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      idle_all();
      bus.m_req_ = 4'b0001;
      while (exp_q.size() > 0) begin
         k = exp_q.pop_front();
         step();
         n_tests++; if (bus.m_grnt_ !== ~(4'd1 << k)) begin n_fail++; $display("FAIL rr_grant: got %b expected %b", bus.m_grnt_, ~(4'd1 << k)); end
         bus.m_req_ = 4'b0000;
         a = mk_addr(0, int'(k) * 16 + 3);
         drive_master(k, 1'b0, 1'b0, a, 1'b0, 32'h1111_0000 + 32'(k));
         drive_slave(0, 1'b0, 32'h0);
         #1;
         n_tests++; if (bus.s_addr !== a || bus.m_rdy_ !== 1'b0) begin n_fail++; $display("FAIL rr_access: got addr %h rdy %b expected %h 0", bus.s_addr, bus.m_rdy_, a); end
         step();
         drive_master(k, 1'b1, 1'b1, a, 1'b0, 0);
         #1;
         n_tests++; if (bus.m_grnt_ !== ~(4'd1 << k)) begin n_fail++; $display("FAIL rr_latency: got %b expected %b", bus.m_grnt_, ~(4'd1 << k)); end
      end
   endtask

   task automatic test_read();
      idle_all();
      bus.m_req_[0] = 1'b0;
      step();
      n_tests++; if (bus.m_grnt_ !== 4'b1110) begin n_fail++; $display("FAIL read_grant: got %b expected 1110", bus.m_grnt_); end
      // byte address 0x1000_0004 is word address 0x0400_0001 -> window 0
      drive_master(0, 1'b0, 1'b0, 30'h0400_0001, 1'b1, 0);
      drive_slave(0, 1'b1, 32'h0);
      for (int c = 0; c < 3; c++) begin
         if (c == 2) drive_slave(0, 1'b0, 32'hDEAD_BEEF);
         #1;
         n_tests++; if (bus.s_cs_ !== 8'hFE || bus.s_as_ !== 1'b0) begin n_fail++; $display("FAIL read_cs: got cs %h as %b expected fe 0", bus.s_cs_, bus.s_as_); end
         if (c < 2) begin
            n_tests++; if (bus.m_rdy_ !== 1'b1) begin n_fail++; $display("FAIL read_wait_rdy: cycle %0d got %b expected 1", c, bus.m_rdy_); end
            step();
         end else begin
            n_tests++; if (bus.m_rdy_ !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'hDEAD_BEEF)
               begin n_fail++; $display("FAIL read_done: got rdy %b err %b data %h expected 0 0 deadbeef", bus.m_rdy_, bus.m_err, bus.m_rd_data); end
            n_tests++; if (dbg_wcnt !== 3'd2) begin n_fail++; $display("FAIL read_wcnt: got %0d expected 2", dbg_wcnt); end
         end
      end
      step();
      drive_slave(0, 1'b1, 32'h0);
      bus.m_as_[0] = 1'b1;
      #1;
      n_tests++; if (bus.m_rdy_ !== 1'b1 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL read_after: got rdy %b state %b expected 1 0", bus.m_rdy_, dbg_state); end
   endtask

   task automatic test_unpopulated();
      drive_slave(7, 1'b0, 32'h7777_7777);
      drive_master(0, 1'b0, 1'b0, mk_addr(7, 9), 1'b1, 0);
      #1;
      n_tests++; if (bus.m_rdy_ !== 1'b0 || bus.m_err !== 1'b1) begin n_fail++; $display("FAIL unpop_rdy_err: got %b/%b expected 0/1", bus.m_rdy_, bus.m_err); end
      n_tests++; if (bus.s_cs_ !== 8'hFF || bus.s_as_ !== 1'b1) begin n_fail++; $display("FAIL unpop_cs_as: got %h/%b expected ff/1", bus.s_cs_, bus.s_as_); end
      n_tests++; if (bus.m_rd_data !== 32'h0) begin n_fail++; $display("FAIL unpop_data: got %h expected 0", bus.m_rd_data); end
      step();
      bus.m_as_[0] = 1'b1;
      drive_slave(7, 1'b1, 32'h0);
      #1;
      n_tests++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL unpop_state: got %b expected 0", dbg_state); end
   endtask

   task automatic test_watchdog(input bit race);
      drive_slave(3, 1'b1, 32'hA5A5_0003);
      drive_master(0, 1'b0, 1'b0, mk_addr(3, 32'h123), 1'b1, 0);
      for (int c = 0; c <= TMO; c++) begin
         if (race && c == TMO) drive_slave(3, 1'b0, 32'h1234_5678);
         #1;
         if (c < TMO) begin
            n_tests++; if (bus.m_rdy_ !== 1'b1 || bus.m_rd_data !== 32'hA5A5_0003) begin n_fail++; $display("FAIL wd_wait: cycle %0d got rdy %b data %h expected 1 a5a50003", c, bus.m_rdy_, bus.m_rd_data); end
            step();
         end else if (!race) begin
            n_tests++; if (bus.m_rdy_ !== 1'b0 || bus.m_err !== 1'b1 || bus.m_rd_data !== 32'h0) begin n_fail++; $display("FAIL wd_timeout: got rdy %b err %b data %h expected 0 1 0", bus.m_rdy_, bus.m_err, bus.m_rd_data); end
         end else begin
            n_tests++; if (bus.m_rdy_ !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wd_race: got rdy %b err %b data %h expected 0 0 12345678", bus.m_rdy_, bus.m_err, bus.m_rd_data); end
         end
      end
      step();
      bus.m_as_[0] = 1'b1;
      drive_slave(3, 1'b1, 32'h0);
      #1;
      n_tests++; if (dbg_state !== 1'b0 || dbg_wcnt !== 3'd0 || bus.m_rdy_ !== 1'b1) begin n_fail++; $display("FAIL wd_after: got state %b wcnt %0d rdy %b expected 0 0 1", dbg_state, dbg_wcnt, bus.m_rdy_); end
   endtask

   task automatic test_reset_mid_access();
      int hit;
      idle_all();
      bus.m_req_[2] = 1'b0;
      step();
      n_tests++; if (dbg_owner !== 2'd2 || bus.m_grnt_ !== 4'b1011) begin n_fail++; $display("FAIL rma_owner2: got %0d/%b expected 2/1011", dbg_owner, bus.m_grnt_); end
      drive_master(2, 1'b0, 1'b0, mk_addr(1, 7), 1'b1, 0);
      drive_slave(1, 1'b1, 32'h0);
      step();
      step();
      n_tests++; if (dbg_wcnt !== 3'd2 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL rma_wcnt2: got %0d/%b expected 2/1", dbg_wcnt, dbg_state); end
      rst = 1'b0;
      #1;
      n_tests++; if (bus.s_as_ !== 1'b1 || bus.m_rdy_ !== 1'b1 || bus.s_cs_ !== 8'hFF) begin n_fail++; $display("FAIL rma_forced: got as %b rdy %b cs %h expected 1 1 ff", bus.s_as_, bus.m_rdy_, bus.s_cs_); end
      step();
      n_tests++; if (dbg_owner !== 2'd0 || dbg_wcnt !== 3'd0 || bus.m_grnt_ !== 4'b1110) begin n_fail++; $display("FAIL rma_cleared: got owner %0d wcnt %0d grant %b expected 0 0 1110", dbg_owner, dbg_wcnt, bus.m_grnt_); end
      rst = 1'b1;
      drive_master(2, 1'b1, 1'b1, 0, 1'b1, 0);
      drive_master(0, 1'b0, 1'b0, mk_addr(1, 8), 1'b1, 0);
      hit = -1;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (bus.m_rdy_ === 1'b0) begin hit = k; break; end
         step();
      end
      n_tests++; if (hit != TMO || bus.m_err !== 1'b1) begin n_fail++; $display("FAIL rma_full_timeout: got error at cycle %0d err %b expected cycle %0d err 1", hit, bus.m_err, TMO); end
      step();
      idle_all();
   endtask

   task automatic test_random();
      int own, age, nxt_own, nxt_age, sel, best_d, d;
      logic [AW-1:0] a;
      logic strobe, pop, srdy, e_as, e_rdy, e_err;
      logic [3:0] e_grnt;
      logic [7:0] e_cs;
      logic [DW-1:0] e_rd;
      idle_all();
      rst = 1'b0;
      step();
      rst = 1'b1;
      own = 0;
      age = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 63) != 0);
         for (int i = 0; i < NM; i++)
            drive_master(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), AW'($urandom), 1'($urandom_range(0, 1)), $urandom);
         for (int j = 0; j < NS; j++) drive_slave(j, ($urandom_range(0, 3) != 0), $urandom);
         #1;
         a      = bus.m_addr[own*AW +: AW];
         sel    = int'(a >> (AW - 3));
         strobe = rst && !bus.m_as_[own];
         pop    = SEN[sel];
         srdy   = bus.s_rdy_[sel];
         e_grnt = ~(4'd1 << own);
         e_as = 1'b1; e_cs = 8'hFF; e_rdy = 1'b1; e_err = 1'b0; e_rd = '0;
         if (strobe && !pop) begin
            e_rdy = 1'b0; e_err = 1'b1;
         end else if (strobe) begin
            e_as = 1'b0;
            e_cs = ~(8'd1 << sel);
            if (age == TMO && srdy) begin
               e_rdy = 1'b0; e_err = 1'b1;
            end else begin
               e_rdy = srdy; e_rd = bus.s_rd_data[sel*DW +: DW];
            end
         end
         n_tests++; if (bus.m_grnt_ !== e_grnt) begin n_fail++; $display("FAIL rnd_grant: n=%0d got %b expected %b", n, bus.m_grnt_, e_grnt); end
         n_tests++; if (bus.s_as_ !== e_as || bus.s_cs_ !== e_cs) begin n_fail++; $display("FAIL rnd_as_cs: n=%0d got %b/%h expected %b/%h", n, bus.s_as_, bus.s_cs_, e_as, e_cs); end
         n_tests++; if (bus.m_rdy_ !== e_rdy || bus.m_err !== e_err || bus.m_rd_data !== e_rd)
            begin n_fail++; $display("FAIL rnd_resp: n=%0d got %b/%b/%h expected %b/%b/%h", n, bus.m_rdy_, bus.m_err, bus.m_rd_data, e_rdy, e_err, e_rd); end
         n_tests++; if (bus.s_addr !== a || bus.s_rw !== bus.m_rw[own] || bus.s_wr_data !== bus.m_wr_data[own*DW +: DW])
            begin n_fail++; $display("FAIL rnd_mux: n=%0d got addr %h expected %h", n, bus.s_addr, a); end
         // reference next state: owner by cyclic distance, age = cycles waited
         if (!rst) begin
            nxt_own = 0; nxt_age = 0;
         end else begin
            nxt_own = own;
            if (bus.m_req_[own]) begin
               best_d = NM;
               for (int j = 0; j < NM; j++) begin
                  d = (j - own + NM) % NM;
                  if (j != own && !bus.m_req_[j] && d < best_d) begin best_d = d; nxt_own = j; end
               end
            end
            nxt_age = (strobe && pop && srdy && age < TMO) ? age + 1 : 0;
         end
         step();
         own = nxt_own;
         age = nxt_age;
         n_tests++; if (dbg_owner !== 2'(own) || dbg_wcnt !== 3'(age) || dbg_state !== (age != 0))
            begin n_fail++; $display("FAIL rnd_regs: n=%0d got owner %0d wcnt %0d expected %0d %0d", n, dbg_owner, dbg_wcnt, own, age); end
      end
      rst = 1'b1;
      idle_all();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_read();
      test_unpopulated();
      test_watchdog(1'b0);
      test_watchdog(1'b1);
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_rr.md
# bus_rr

Parametrised shared-bus interconnect: the next generation of the four-master, eight-slave bus. It generalises master count, slave count, address width and data width, replaces the fixed channel set with packed vectors, and adds three things the previous bus lacked: a registered round-robin arbiter, a slave-population mask, and a per-access watchdog that returns a bus error. It sits between the CPU, DMA and debug masters and the ROM, SPM, timer, UART and GPIO slaves, as a drop-in replacement for the bus top level.

## Interface
- NUM_M, 4: number of masters, 2..8.
- NUM_S, 8: number of slave windows, power of two, 2..16.
- ADDR_W, 30: word-address width.
- DATA_W, 32: data width.
- S_EN, all ones: NUM_S-bit mask; bit i = 1 means slave i is populated.
- TIMEOUT, 255: wait-cycle limit per access; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock.
- rst  in  1  reset, synchronous, active-low.
- m_req_  in  NUM_M  bus request per master, active-low.
- m_grnt_  out  NUM_M  grant per master, active-low, one-hot-low.
- m_addr  in  NUM_M*ADDR_W  packed addresses; master i at bits [i*ADDR_W +: ADDR_W].
- m_as_  in  NUM_M  address strobe, active-low.
- m_rw  in  NUM_M  1 = read, 0 = write.
- m_wr_data  in  NUM_M*DATA_W  packed write data.
- m_rd_data  out  DATA_W  read data, broadcast to all masters.
- m_rdy_  out  1  access complete, active-low, broadcast.
- m_err  out  1  access completed with error; valid only while m_rdy_ = 0.
- s_addr  out  ADDR_W  address of the owner.
- s_as_  out  1  strobe to the slaves, active-low.
- s_rw  out  1  owner rw.
- s_wr_data  out  DATA_W  owner write data.
- s_cs_  out  NUM_S  chip selects, active-low, at most one low.
- s_rd_data  in  NUM_S*DATA_W  packed slave read data.
- s_rdy_  in  NUM_S  slave ready, active-low.

## Operation
- Owner register: log2(NUM_M) bits. Exactly one m_grnt_ bit is low at all times, the one for the owner.
- Arbitration is evaluated every cycle.
  - If the owner's m_req_ = 0, the owner is kept.
  - Otherwise the next owner is the first master with m_req_ = 0, scanning owner+1, owner+2, … modulo NUM_M.
  - If no master requests, the owner is kept.
  - The new owner is registered and takes effect the next cycle.
- Protocol: a master holds req_, as_, addr, rw and wr_data until it samples m_rdy_ = 0. It keeps req_ low for the whole access.
- Master mux (combinational): s_addr, s_as_, s_rw and s_wr_data come from the owner.
- Decode:
  - sel = s_addr[ADDR_W-1 -: log2(NUM_S)].
  - s_cs_[sel] = 0 when S_EN[sel] = 1; otherwise all s_cs_ are high.
- Slave mux: m_rd_data = s_rd_data of sel and m_rdy_ = s_rdy_[sel] when cs is active. Otherwise m_rd_data = 0, m_rdy_ = 1 and m_err = 0, except for the error cases below.
- Unpopulated slave (S_EN[sel] = 0 while s_as_ = 0):
  - s_as_ to the slaves is forced to 1.
  - m_rdy_ = 0, m_err = 1 and m_rd_data = 0 in the same cycle.
- Watchdog FSM, states IDLE and WAIT; counter wcnt of width clog2(TIMEOUT+1).
  - IDLE → WAIT when s_as_ = 0, cs is valid and s_rdy_[sel] = 1. wcnt then counts 1, 2, … each cycle.
  - WAIT → IDLE on slave ready, on s_as_ = 1, or on timeout. wcnt clears to 0.
  - Timeout: when wcnt = TIMEOUT in WAIT, m_rdy_ = 0, m_err = 1 and m_rd_data = 0 for that one cycle.
  - Slave ready in the same cycle as the timeout: the slave wins and m_err = 0.
  - TIMEOUT = 0: the FSM stays in IDLE.

## Timing
- While rst = 0 at a clk edge: owner ← 0, FSM ← IDLE, wcnt ← 0.
- While rst is low, the combinational outputs are also forced: s_as_ = 1, s_cs_ all 1, m_rdy_ = 1, m_err = 0.
- Output values after reset:
  - m_grnt_ = all ones except bit 0.
  - s_as_ = 1; s_cs_ all 1; m_rdy_ = 1; m_err = 0; m_rd_data = 0.
  - s_addr, s_rw and s_wr_data follow master 0.
- Grant latency is 1 cycle after the owner's req_ rises, or after a request to an idle bus.
- Decode and mux paths are combinational. A zero-wait slave completes in the same cycle as as_.
- Reset asserted mid-access aborts the access. No m_rdy_ is produced for it.
- Bus changes ownership only at a clock edge. Protocol guarantees no access is in flight at that moment.

## Test plan
- Reset and idle grant: hold rst low 3 cycles, then release with all req_ = 1 → m_grnt_ = 4'b1110, s_as_ = 1, m_rdy_ = 1, m_err = 0.
- Round robin: owner 0, masters 1, 2 and 3 request continuously, each releases after one access → grant order 1, 2, 3, 0(if requesting), 1, each change 1 cycle after release.
- Read through a populated slave: master 0 reads addr 0x1000_0004 (sel = 0), slave 0 returns 0xDEADBEEF with rdy_ low on the 3rd cycle → m_rd_data = 0xDEADBEEF, m_rdy_ = 0 and m_err = 0 in that cycle only.
- Unpopulated slave: S_EN = 8'b0111_1111, access to sel = 7 → same-cycle m_rdy_ = 0, m_err = 1, s_cs_ = 8'hFF, s_as_ = 1.
- Watchdog with TIMEOUT = 4:
  - Slave never readies → m_rdy_ = 0 and m_err = 1 exactly in the cycle where wcnt = 4 (as_ at cycle 0).
  - Repeat with slave rdy_ in that same cycle → m_err = 0.
- Reset mid-access: assert rst during WAIT with wcnt = 2 → next cycle owner = 0 and wcnt = 0. After release, a new access times out at the full TIMEOUT.
